mem_bus_ctrl: RTL and testbench

- Memory/I-O bus stage directly downstream of the execution unit.
- Consumes the per-micro-op access request (addr, wr_data, we, m_io, byteop) and runs Wishbone-style classic bus cycles.
- Returns read data as memout and holds the datapath with block until the access completes.
- Splits unaligned word accesses into two byte-lane bus cycles.

---
 rtl/mem_bus_ctrl_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory/I-O bus stage.
//   - FSM state encoding
//   - byte-lane select codes
//   - default address widths, so the core and its users agree
package mem_bus_ctrl_pkg;

   localparam int AW_DEF  = 20;
   localparam int IOW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CYC1 = 2'd1,
      CYC2 = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] SEL_LO = 2'b01;
   localparam logic [1:0] SEL_HI = 2'b10;
   localparam logic [1:0] SEL_W  = 2'b11;

endpackage

// File: rtl/mem_lane_align.sv
// Write-lane steering and read-byte assembly for one bus access.
//   a0       : byte address bit 0
//   byteop   : 1 = byte access
//   phase2   : steering for the second half of a split word access
//   we       : write access (read cycles drive no write data)
//   wr_data  : write data from the execution unit
//   dat_i    : bus read data of the current cycle
//   rd_lo    : low byte captured by the first half of a split read
//   sel      : byte-lane selects
//   dat_o    : bus write data
//   rd_data  : assembled read result for the completing cycle
module mem_lane_align
   import mem_bus_ctrl_pkg::*;
(
   input  logic        a0,
   input  logic        byteop,
   input  logic        phase2,
   input  logic        we,
   input  logic [15:0] wr_data,
   input  logic [15:0] dat_i,
   input  logic [7:0]  rd_lo,
   output logic [1:0]  sel,
   output logic [15:0] dat_o,
   output logic [15:0] rd_data
);

   always_comb begin
      sel     = SEL_W;
      dat_o   = wr_data;
      rd_data = dat_i;
      if (byteop) begin
         sel     = a0 ? SEL_HI : SEL_LO;
         dat_o   = {wr_data[7:0], wr_data[7:0]};
         rd_data = {8'h00, (a0 ? dat_i[15:8] : dat_i[7:0])};
      end else if (a0) begin
         // Unaligned word: low byte travels on the odd lane first,
         // high byte on the even lane of the following word.
         if (!phase2) begin
            sel   = SEL_HI;
            dat_o = {wr_data[7:0], 8'h00};
         end else begin
            sel   = SEL_LO;
            dat_o = {8'h00, wr_data[15:8]};
         end
         rd_data = {dat_i[7:0], rd_lo};
      end
      if (!we) begin
         dat_o = 16'h0000;
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory/I-O bus stage: runs Wishbone classic cycles for each access
// request, splitting unaligned word accesses into two byte-lane cycles.
//   clk, rst (sync, active-low)
//   req/addr/wr_data/we/m_io/byteop : access request from execution unit
//   memout : read result, valid while block is low in DONE
//   block  : stall to execution unit
//   wb_*   : Wishbone master interface (all outputs registered)
//
// state | meaning
// IDLE  | no bus activity, waiting for req
// CYC1  | first (or only) bus cycle in progress
// CYC2  | second half of a split unaligned word access
// DONE  | result valid, execution unit released for one cycle
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
#(
   parameter int AW  = AW_DEF,
   parameter int IOW = IOW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wr_data,
   input  logic          we,
   input  logic          m_io,
   input  logic          byteop,
   output logic [15:0]   memout,
   output logic          block,
   output logic [AW-2:0] wb_adr_o,
   output logic [1:0]    wb_sel_o,
   output logic [15:0]   wb_dat_o,
   input  logic [15:0]   wb_dat_i,
   output logic          wb_we_o,
   output logic          wb_tga_o,
   output logic          wb_cyc_o,
   output logic          wb_stb_o,
   input  logic          wb_ack_i
);

   localparam logic [AW-2:0] IO_WMASK = {{(AW-IOW){1'b0}}, {(IOW-1){1'b1}}};
   localparam logic [AW-2:0] WORD_ONE = {{(AW-2){1'b0}}, 1'b1};

   state_t        state;
   logic          we_q, mio_q, bop_q;
   logic [15:0]   wd_q;
   logic [AW-1:0] addr_q;
   logic [7:0]    rd_lo;

   logic [AW-1:0] addr_m;
   logic [AW-2:0] wadr_nx;
   logic          idle, split_q;
   logic          ln_a0, ln_bop, ln_we;
   logic [15:0]   ln_wd;
   logic [1:0]    ln_sel;
   logic [15:0]   ln_dat, ln_rd;

   assign block   = req && (state != DONE);
   assign idle    = (state == IDLE);
   assign split_q = !bop_q && addr_q[0];

   // I/O space only decodes IOW bits; upper address bits read as zero.
   assign addr_m  = m_io ? {{(AW-IOW){1'b0}}, addr[IOW-1:0]} : addr;

   // Second half of a split always starts on the next even byte, so the
   // word address simply increments and wraps within its space.
   assign wadr_nx = (addr_q[AW-1:1] + WORD_ONE) & (mio_q ? IO_WMASK : '1);

   // Live request drives steering when launching; latched copy afterwards.
   assign ln_a0  = idle ? addr_m[0] : addr_q[0];
   assign ln_bop = idle ? byteop    : bop_q;
   assign ln_we  = idle ? we        : we_q;
   assign ln_wd  = idle ? wr_data   : wd_q;

   mem_lane_align u_lane (
      .a0      (ln_a0),
      .byteop  (ln_bop),
      .phase2  (!idle),
      .we      (ln_we),
      .wr_data (ln_wd),
      .dat_i   (wb_dat_i),
      .rd_lo   (rd_lo),
      .sel     (ln_sel),
      .dat_o   (ln_dat),
      .rd_data (ln_rd)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         we_q     <= 1'b0;
         mio_q    <= 1'b0;
         bop_q    <= 1'b0;
         wd_q     <= 16'h0000;
         addr_q   <= '0;
         rd_lo    <= 8'h00;
         memout   <= 16'h0000;
         wb_adr_o <= '0;
         wb_sel_o <= 2'b00;
         wb_dat_o <= 16'h0000;
         wb_we_o  <= 1'b0;
         wb_tga_o <= 1'b0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state    <= CYC1;
                  we_q     <= we;
                  mio_q    <= m_io;
                  bop_q    <= byteop;
                  wd_q     <= wr_data;
                  addr_q   <= addr_m;
                  wb_adr_o <= addr_m[AW-1:1];
                  wb_sel_o <= ln_sel;
                  wb_dat_o <= ln_dat;
                  wb_we_o  <= we;
                  wb_tga_o <= m_io;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
               end
            end
            CYC1: begin
               if (wb_ack_i) begin
                  if (split_q) begin
                     state    <= CYC2;
                     rd_lo    <= wb_dat_i[15:8];
                     wb_adr_o <= wadr_nx;
                     wb_sel_o <= ln_sel;
                     wb_dat_o <= ln_dat;
                  end else begin
                     state    <= DONE;
                     wb_cyc_o <= 1'b0;
                     wb_stb_o <= 1'b0;
                     if (!we_q) memout <= ln_rd;
                  end
               end
            end
            CYC2: begin
               if (wb_ack_i) begin
                  state    <= DONE;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  if (!we_q) memout <= ln_rd;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
   import mem_bus_ctrl_pkg::*;

   localparam int AW  = AW_DEF;
   localparam int IOW = IOW_DEF;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [15:0]   wr_data = '0;
   logic          we = 1'b0, m_io = 1'b0, byteop = 1'b0;
   logic [15:0]   memout;
   logic          block;
   logic [AW-2:0] wb_adr_o;
   logic [1:0]    wb_sel_o;
   logic [15:0]   wb_dat_o;
   logic [15:0]   wb_dat_i = '0;
   logic          wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o;
   logic          wb_ack_i = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] exp_mem = 16'h0000;

   mem_bus_ctrl #(.AW(AW), .IOW(IOW)) dut (
      .clk(clk), .rst(rst), .req(req), .addr(addr), .wr_data(wr_data),
      .we(we), .m_io(m_io), .byteop(byteop), .memout(memout), .block(block),
      .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_tga_o(wb_tga_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One complete access. The bench acts as the bus slave: it acks each
   // cycle after `waits` wait states, returning d1 then d2 as read data.
   task automatic run_access(input logic [19:0] a, input logic [15:0] w,
                             input logic iwe, input logic imio, input logic ibop,
                             input int waits, input logic [15:0] d1, input logic [15:0] d2);
      int           n, blk;
      logic [19:0]  mask, ab, ab2;
      logic [18:0]  e_adr [2];
      logic [1:0]   e_sel [2];
      logic [15:0]  e_dat [2];
      logic [15:0]  result;

      // Reference: byte-level rules with plain arithmetic.
      mask = imio ? 20'h0FFFF : 20'hFFFFF;
      ab   = a & mask;
      ab2  = (ab + 20'd1) & mask;
      if (ibop) begin
         n = 1;
         e_adr[0] = ab[19:1];
         e_sel[0] = ab[0] ? 2'b10 : 2'b01;
         e_dat[0] = {w[7:0], w[7:0]};
         result   = ab[0] ? {8'h00, d1[15:8]} : {8'h00, d1[7:0]};
      end else if (!ab[0]) begin
         n = 1;
         e_adr[0] = ab[19:1];
         e_sel[0] = 2'b11;
         e_dat[0] = w;
         result   = d1;
      end else begin
         n = 2;
         e_adr[0] = ab[19:1];
         e_sel[0] = 2'b10;
         e_dat[0] = {w[7:0], 8'h00};
         e_adr[1] = ab2[19:1];
         e_sel[1] = 2'b01;
         e_dat[1] = {8'h00, w[15:8]};
         result   = {d2[7:0], d1[15:8]};
      end

      @(negedge clk);
      req = 1'b1; addr = a; wr_data = w; we = iwe; m_io = imio; byteop = ibop;
      wb_ack_i = 1'b0;
      #1;
      blk = block ? 1 : 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         wb_ack_i = 1'b0;
         // Request inputs may change once latched; the cycle must not care.
         addr = 20'($urandom); wr_data = 16'($urandom);
         we = 1'($urandom); m_io = 1'($urandom); byteop = 1'($urandom);
         for (int k = 0; k <= waits; k++) begin
            if (k > 0) @(negedge clk);
            if (block) blk++;
            chk("cyc",  {wb_cyc_o, wb_stb_o}, 2'b11);
            chk("adr",  wb_adr_o, e_adr[c]);
            chk("sel",  wb_sel_o, e_sel[c]);
            chk("we_o", wb_we_o, iwe);
            chk("tga",  wb_tga_o, imio);
            if (iwe) chk("dat_o", wb_dat_o, e_dat[c]);
            chk("memout_hold", memout, exp_mem);
            wb_dat_i = 16'($urandom);
         end
         wb_ack_i = 1'b1;
         wb_dat_i = (c == 0) ? d1 : d2;
      end
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_dat_i = 16'($urandom);
      if (!iwe) exp_mem = result;
      chk("done_block", block, 1'b0);
      chk("done_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
      chk("memout", memout, exp_mem);
      chk("block_cycles", blk, 1 + n * (waits + 1));
      req = 1'b0;
      @(negedge clk);
      chk("idle_cyc", wb_cyc_o, 1'b0);
      chk("idle_memout", memout, exp_mem);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o, wb_tga_o}, 4'h0);
      chk("rst_sel", wb_sel_o, 2'b00);
      chk("rst_adr", wb_adr_o, 19'h0);
      chk("rst_dat", wb_dat_o, 16'h0);
      chk("rst_memout", memout, 16'h0);

      // Directed cases from the block's test plan.
      run_access(20'h12344, 16'h1111, 1'b0, 1'b0, 1'b0, 0, 16'hBEEF, 16'h0000);
      run_access(20'h00101, 16'h00A5, 1'b1, 1'b0, 1'b1, 0, 16'h0000, 16'h0000);
      run_access(20'h00FFF, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 16'h3400, 16'h0012);
      chk("unaligned_value", memout, 16'h1234);
      run_access(20'hFFFFF, 16'hCAFE, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 16'h0000);
      run_access(20'h0FFFF, 16'hCAFE, 1'b1, 1'b1, 1'b0, 1, 16'h0000, 16'h0000);
      run_access(20'h00200, 16'h0000, 1'b0, 1'b0, 1'b0, 3, 16'h5A5A, 16'h0000);
      run_access(20'h00203, 16'h0000, 1'b0, 1'b1, 1'b1, 2, 16'h9C00, 16'h0000);

      // Ack while idle is ignored.
      @(negedge clk);
      wb_ack_i = 1'b1; wb_dat_i = 16'hDEAD;
      @(negedge clk);
      wb_ack_i = 1'b0;
      chk("idle_ack_cyc", wb_cyc_o, 1'b0);
      chk("idle_ack_memout", memout, exp_mem);

      // Reset in the middle of CYC1, then a late ack.
      req = 1'b1; addr = 20'h00400; we = 1'b0; m_io = 1'b0; byteop = 1'b0;
      @(negedge clk);
      chk("pre_rst_cyc", wb_cyc_o, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1; req = 1'b0;
      exp_mem = 16'h0000;
      chk("mid_rst_cyc", {wb_cyc_o, wb_stb_o}, 2'b00);
      chk("mid_rst_memout", memout, 16'h0000);
      chk("mid_rst_adr", wb_adr_o, 19'h0);
      wb_ack_i = 1'b1; wb_dat_i = 16'hFFFF;
      @(negedge clk);
      wb_ack_i = 1'b0;
      chk("late_ack_cyc", wb_cyc_o, 1'b0);
      chk("late_ack_memout", memout, 16'h0000);

      // Randomized accesses.
      for (int i = 0; i < 60; i++) begin
         run_access(20'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), int'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
